// File: rtl/psram_arb_pkg.sv
// Shared definitions for the PSRAM arbiter.
//   state_e : arbiter FSM states
//   port_e  : requester identifiers (A = display fetch, B = host/command)
//   ADDR_W_DEF / DATA_W_DEF : default word address and data widths
package psram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PSRAM controller.
// Port A (display fetch) has priority; port B (host/command) is guaranteed a
// grant after STARVE_LIMIT consecutive A grants taken while B was waiting.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   i_x_req/we/addr/din           requester x (a|b) level request and fields
//   o_x_done/o_x_err/o_x_dout     completion pulse, timeout flag, held read data
//   o_psram_stb/we/addr/din       command to the PSRAM controller
//   i_psram_busy/done/dout        controller status and read data
//   o_busy                        arbiter is not idle
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_din,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_din,
  output logic              o_a_done,
  output logic              o_a_err,
  output logic [DATA_W-1:0] o_a_dout,
  output logic              o_b_done,
  output logic              o_b_err,
  output logic [DATA_W-1:0] o_b_dout,
  output logic              o_psram_stb,
  output logic              o_psram_we,
  output logic [ADDR_W-1:0] o_psram_addr,
  output logic [DATA_W-1:0] o_psram_din,
  input  logic              i_psram_busy,
  input  logic              i_psram_done,
  input  logic [DATA_W-1:0] i_psram_dout,
  output logic              o_busy
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  port_e               port_q,  port_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   din_q,   din_d;
  logic                err_q,   err_d;
  logic [TO_W-1:0]     to_q,    to_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0]   a_dout_q, a_dout_d;
  logic [DATA_W-1:0]   b_dout_q, b_dout_d;
  logic                capture;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    err_d    = err_q;
    to_d     = to_q;
    starve_d = starve_q;
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    capture  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_a_req || i_b_req) begin
          err_d   = 1'b0;
          to_d    = '0;
          state_d = ISSUE;
          // B takes the slot if A is absent or A has used up its run of grants.
          if (i_b_req && (!i_a_req || starve_q == SC_W'(STARVE_LIMIT))) begin
            port_d   = PORT_B;
            we_d     = i_b_we;
            addr_d   = i_b_addr;
            din_d    = i_b_din;
            starve_d = '0;
          end else begin
            port_d = PORT_A;
            we_d   = i_a_we;
            addr_d = i_a_addr;
            din_d  = i_a_din;
            if (!i_b_req)
              starve_d = '0;
            else if (starve_q != SC_W'(STARVE_LIMIT))
              starve_d = starve_q + SC_W'(1);
          end
        end
      end
      ISSUE: begin
        if (i_psram_busy) begin
          if (i_psram_done) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = XFER;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      XFER: begin
        if (i_psram_done) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture && !we_q) begin
      if (port_q == PORT_A) a_dout_d = i_psram_dout;
      else                  b_dout_d = i_psram_dout;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      port_q   <= PORT_A;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      to_q     <= '0;
      starve_q <= '0;
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      err_q    <= err_d;
      to_q     <= to_d;
      starve_q <= starve_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  // Outputs decode the state register directly so reset clears them at once.
  assign o_busy       = (state_q != IDLE);
  assign o_psram_stb  = (state_q == ISSUE);
  assign o_psram_we   = we_q;
  assign o_psram_addr = addr_q;
  assign o_psram_din  = din_q;
  assign o_a_done     = (state_q == RESP) && (port_q == PORT_A);
  assign o_b_done     = (state_q == RESP) && (port_q == PORT_B);
  assign o_a_err      = o_a_done && err_q;
  assign o_b_err      = o_b_done && err_q;
  assign o_a_dout     = a_dout_q;
  assign o_b_dout     = b_dout_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a scoreboard queue and a PSRAM model.
module tb_psram_arbiter;

  localparam int MD_NORMAL = 0;
  localparam int MD_SAME   = 1;
  localparam int MD_NEVER  = 2;
  localparam int MD_HANG   = 3;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_din = '0, b_din = '0;
  logic        a_done, a_err, b_done, b_err;
  logic [15:0] a_dout, b_dout;
  logic        p_stb, p_we;
  logic [23:0] p_addr;
  logic [15:0] p_din;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_dout = '0;
  logic        busy;

  typedef struct {
    logic        port;
    logic        err;
    logic [15:0] dout;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mode = MD_NORMAL;
  int          last_done_cyc = 0;
  logic [15:0] mem [int];

  psram_arbiter #(
    .ADDR_W(24), .DATA_W(16), .STARVE_LIMIT(4), .TIMEOUT(255)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_din(a_din),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_din(b_din),
    .o_a_done(a_done), .o_a_err(a_err), .o_a_dout(a_dout),
    .o_b_done(b_done), .o_b_err(b_err), .o_b_dout(b_dout),
    .o_psram_stb(p_stb), .o_psram_we(p_we), .o_psram_addr(p_addr), .o_psram_din(p_din),
    .i_psram_busy(m_busy), .i_psram_done(m_done), .i_psram_dout(m_dout),
    .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // PSRAM controller model; inputs change on the falling edge.
  task automatic model();
    int phase = 0;
    int wt = 0;
    logic        mw;
    logic [23:0] ma;
    logic [15:0] md;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        m_busy = 1'b0; m_done = 1'b0; phase = 0;
      end else begin
        m_done = 1'b0;
        case (phase)
          0: if (p_stb) begin
            mw = p_we; ma = p_addr; md = p_din;
            case (mode)
              MD_NORMAL: begin m_busy = 1'b1; wt = 2; phase = 1; end
              MD_SAME: begin
                m_busy = 1'b1; m_done = 1'b1; m_dout = 16'hBEEF;
                last_done_cyc = cyc; phase = 2;
              end
              MD_HANG: begin m_busy = 1'b1; phase = 3; end
              default: ;
            endcase
          end
          1: begin
            wt--;
            if (wt == 0) begin
              m_busy = 1'b0; m_done = 1'b1;
              if (mw) mem[int'(ma)] = md;
              else m_dout = mem.exists(int'(ma)) ? mem[int'(ma)] : 16'h0000;
              last_done_cyc = cyc; phase = 2;
            end
          end
          2: begin m_busy = 1'b0; phase = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic gp, ge;
    logic [15:0] gd;
    forever begin
      @(negedge clk);
      if (rstn_i && (a_done || b_done)) begin
        chk("done_exclusive", {31'd0, a_done & b_done}, 32'd0);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got a=%0b b=%0b want none", a_done, b_done);
        end else begin
          e  = sb.pop_front();
          gp = b_done;
          ge = gp ? b_err : a_err;
          gd = gp ? b_dout : a_dout;
          chk("grant_port", {31'd0, gp}, {31'd0, e.port});
          chk("err_flag", {31'd0, ge}, {31'd0, e.err});
          chk("dout", {16'd0, gd}, {16'd0, e.dout});
          if (!e.err) chk("done_latency", cyc, last_done_cyc + 1);
        end
      end
    end
  endtask

  // Issues one transaction on port a/b and waits (bounded) for its done pulse.
  task automatic xact(input logic port, input logic we, input logic [23:0] addr,
                      input logic [15:0] din, input logic exp_err, input logic [15:0] exp_dout,
                      input bit push, input bit chk_lat, input int max_cyc, output int stb_cyc);
    bit seen = 0;
    if (push) sb.push_back('{port, exp_err, exp_dout});
    if (!port) begin a_req = 1'b1; a_we = we; a_addr = addr; a_din = din; end
    else       begin b_req = 1'b1; b_we = we; b_addr = addr; b_din = din; end
    stb_cyc = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (chk_lat && i == 0) begin
        chk("stb_latency", {31'd0, p_stb}, 32'd1);
        chk("stb_addr", {8'd0, p_addr}, {8'd0, addr});
        chk("stb_we", {31'd0, p_we}, {31'd0, we});
      end
      if (p_stb) stb_cyc++;
      if (!port ? a_done : b_done) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (!port) a_req = 1'b0; else b_req = 1'b0;
  endtask

  initial begin
    int n;
    bit got_xfer;
    fork
      model();
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stb", {31'd0, p_stb}, 32'd0);
    chk("rst_done", {30'd0, a_done, b_done}, 32'd0);
    chk("rst_dout", {a_dout, b_dout}, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);

    // A write then read back
    xact(1'b0, 1'b1, 24'h0001A5, 16'h1234, 1'b0, 16'h0000, 1, 1, 50, n);
    @(negedge clk);
    xact(1'b0, 1'b0, 24'h0001A5, 16'h0000, 1'b0, 16'h1234, 1, 1, 50, n);
    @(negedge clk);
    // B write/read, A at the top address
    xact(1'b1, 1'b1, 24'h000100, 16'hABCD, 1'b0, 16'h0000, 1, 1, 50, n);
    @(negedge clk);
    xact(1'b1, 1'b0, 24'h000100, 16'h0000, 1'b0, 16'hABCD, 1, 1, 50, n);
    @(negedge clk);
    xact(1'b0, 1'b1, 24'hFFFFFF, 16'h5A5A, 1'b0, 16'h1234, 1, 1, 50, n);
    @(negedge clk);
    xact(1'b0, 1'b0, 24'hFFFFFF, 16'h0000, 1'b0, 16'h5A5A, 1, 1, 50, n);
    @(negedge clk);
    chk("b_dout_held", {16'd0, b_dout}, 32'h0000ABCD);

    // Starvation: grant order A,A,A,A,B,A
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 1'b0, 16'h5A5A});
    sb.push_back('{1'b1, 1'b0, 16'hABCD});
    sb.push_back('{1'b0, 1'b0, 16'h5A5A});
    fork
      begin
        int k;
        for (int i = 0; i < 5; i++)
          xact(1'b0, 1'b1, 24'h000300 + 24'(i), 16'h0300 + 16'(i), 1'b0, 16'h0, 0, 0, 100, k);
      end
      begin
        int k;
        xact(1'b1, 1'b1, 24'h000200, 16'h0B0B, 1'b0, 16'h0, 0, 0, 200, k);
      end
    join
    @(negedge clk);
    chk("starve_sb_empty", sb.size(), 0);

    // Busy and done together on B read
    mode = MD_SAME;
    xact(1'b1, 1'b0, 24'h000123, 16'h0000, 1'b0, 16'hBEEF, 1, 1, 50, n);
    @(negedge clk);

    // Controller never answers: timeout abort
    mode = MD_NEVER;
    xact(1'b1, 1'b0, 24'h000456, 16'h0000, 1'b1, 16'hBEEF, 1, 1, 400, n);
    chk("timeout_stb_cycles", n, 255);
    @(negedge clk);
    mode = MD_NORMAL;

    // Reset while in XFER
    mode = MD_HANG;
    a_req = 1'b1; a_we = 1'b0; a_addr = 24'h0001A5;
    got_xfer = 0;
    for (int i = 0; i < 10 && !got_xfer; i++) begin
      @(negedge clk);
      if (busy && !p_stb && m_busy) got_xfer = 1;
    end
    chk("reached_xfer", {31'd0, got_xfer}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_stb", {31'd0, p_stb}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {30'd0, a_done, b_done}, 32'd0);
    a_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_dout", {a_dout, b_dout}, 32'd0);
    mode = MD_NORMAL;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, a_done}, 32'd0);
    xact(1'b0, 1'b0, 24'h0001A5, 16'h0000, 1'b0, 16'h1234, 1, 1, 50, n);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, word address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive A grants while B waits.
REQ-004 Parameter TIMEOUT, default 255, max cycles in ISSUE waiting for i_psram_busy.
REQ-005 clk_i  in  1  single clock (pixel clock domain); all logic on posedge.
REQ-006 rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-007 i_a_req / i_b_req  in  1  request level; A = display fetch, B = host/command.
REQ-008 i_a_we / i_b_we  in  1  1 = write, 0 = read.
REQ-009 i_a_addr / i_b_addr  in  ADDR_W  word address.
REQ-010 i_a_din / i_b_din  in  DATA_W  write data.
REQ-011 o_a_done / o_b_done  out  1  one-cycle completion pulse.
REQ-012 o_a_err / o_b_err  out  1  one-cycle pulse with done on timeout abort.
REQ-013 o_a_dout / o_b_dout  out  DATA_W  read data, held until next read on that port.
REQ-014 o_psram_stb, o_psram_we, o_psram_addr, o_psram_din  out  1/1/ADDR_W/DATA_W  to psram controller.
REQ-015 i_psram_busy, i_psram_done  in  1  controller status; i_psram_dout  in  DATA_W  read data.
REQ-016 o_busy  out  1  high whenever state != IDLE.

Function
REQ-017 States SHALL be IDLE, ISSUE, XFER, RESP; encoding from package.
REQ-018 Requester SHALL hold req, we, addr, din stable from assertion until its done pulse; arbiter latches them at grant.
REQ-019 IDLE: no req -> stay; else grant per REQ-020, latch fields, go ISSUE next cycle.
REQ-020 Priority: A wins over B, except B wins when starve count == STARVE_LIMIT and i_b_req high.
REQ-021 Starve count: +1 on each A grant while i_b_req high; clear on B grant or when i_b_req low at an A grant; saturates at STARVE_LIMIT.
REQ-022 ISSUE: o_psram_stb=1 with latched we/addr/din; on i_psram_busy=1 go XFER (stb low from that cycle's next edge).
REQ-023 ISSUE with i_psram_busy and i_psram_done both high SHALL go directly to RESP, capturing data.
REQ-024 ISSUE timeout counter: TIMEOUT cycles without busy -> stb low, go RESP with err flag set.
REQ-025 XFER: stb=0; on i_psram_done=1 capture i_psram_dout (reads only) and go RESP.
REQ-026 RESP: pulse granted port's done (and err if flagged) for exactly one cycle, then IDLE.
REQ-027 Latency: req seen in IDLE at cycle N -> stb high at N+1; done pulse one cycle after psram done.
REQ-028 Writes SHALL NOT modify o_x_dout; aborted reads SHALL NOT modify o_x_dout.
REQ-029 Non-granted port's req SHALL be ignored until return to IDLE; no preemption.
REQ-030 Minimum one IDLE cycle between transactions (back-to-back grant every ≥4 cycles + psram time).

Reset
REQ-031 rstn_i low SHALL immediately force IDLE, all outputs 0, starve and timeout counters 0, latched fields 0.
REQ-032 Reset mid-transaction SHALL drop o_psram_stb immediately; psram controller shares the same reset; no done issued for the aborted transaction.

Structure
REQ-033 Package psram_arb_pkg SHALL hold state enum, port IDs (PORT_A=0, PORT_B=1), default ADDR_W/DATA_W.
REQ-034 Single module; no sub-module (grant logic and counters inline).

Verification
REQ-035 A write 0x0001A5:0x1234, then A read same address -> o_a_done twice, o_a_dout=0x1234, o_a_err=0.
REQ-036 A and B req high same cycle, STARVE_LIMIT=4, A re-requests continuously -> grant order A,A,A,A,B,A.
REQ-037 psram model never asserts busy -> stb high exactly 255 cycles, then o_b_done and o_b_err pulse together, o_b_dout unchanged.
REQ-038 Model asserts busy and done in same cycle with dout 0xBEEF on B read -> o_b_done next cycle, o_b_dout=0xBEEF.
REQ-039 rstn_i low during XFER -> o_psram_stb=0, o_busy=0 same cycle, no done; after release A read completes normally.
